// File: rtl/see_cone_stim_checker.sv
// see_cone_stim_checker: drives input vectors into a cone under test and its
// golden copy, compares their single-bit outputs, counts qualified mismatches
// and records the first failing vector.
// Optional feature macro: SEE_CHK_EXHAUSTIVE_EN. When it is defined, a binary
// up-counter that walks all 2^N_IN vectors replaces the LFSR.
// LFSR mode supports N_IN from 2 to 16. The tap table covers only that range.
module see_cone_stim_checker #(
    parameter int              N_IN   = 7,
    parameter int              N_VEC  = 128,
    parameter int              SETTLE = 2,
    parameter int              CNT_W  = 16,
    parameter logic [N_IN-1:0] SEED   = 7'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inj_en,
    output logic [N_IN-1:0]   vec_o,
    input  logic              golden_i,
    input  logic              faulty_i,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_vld
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;

    // Reload value of the settle down-counter. It is only used when SETTLE > 0.
    localparam logic [3:0] WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

`ifdef SEE_CHK_EXHAUSTIVE_EN
    localparam logic [N_IN-1:0] START_VAL = '0;
`else
    // Maximal-length Fibonacci tap masks. Bit i stands for polynomial term x^(i+1).
    function automatic logic [15:0] tapsFor(input int n);
        case (n)
            2:       tapsFor = 16'h0003;
            3:       tapsFor = 16'h0006;
            4:       tapsFor = 16'h000C;
            5:       tapsFor = 16'h0014;
            6:       tapsFor = 16'h0030;
            7:       tapsFor = 16'h0060;
            8:       tapsFor = 16'h00B8;
            9:       tapsFor = 16'h0110;
            10:      tapsFor = 16'h0240;
            11:      tapsFor = 16'h0500;
            12:      tapsFor = 16'h0829;
            13:      tapsFor = 16'h100D;
            14:      tapsFor = 16'h2015;
            15:      tapsFor = 16'h6000;
            16:      tapsFor = 16'hD008;
            default: tapsFor = 16'h0000;
        endcase
    endfunction

    localparam logic [N_IN-1:0] TAPS      = N_IN'(tapsFor(N_IN));
    localparam logic [N_IN-1:0] ONE       = N_IN'(1);
    localparam logic [N_IN-1:0] START_VAL = (SEED == '0) ? ONE : SEED;
    localparam int              IDX_W     = $clog2(N_VEC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
`endif

    state_t            state_q, state_d;
    logic [N_IN-1:0]   gen_q, gen_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [3:0]        wait_q, wait_d;
    logic [CNT_W-1:0]  errCnt_q, errCnt_d;
    logic [N_IN-1:0]   firstVec_q, firstVec_d;
    logic              firstVld_q, firstVld_d;
    logic [N_IN-1:0]   genNext;
    logic              lastVec;
    logic              mismatch;

    // Next-state logic: sequences the apply/settle/sample steps for each vector and updates the error record.
    always_comb begin
        state_d    = state_q;
        gen_d      = gen_q;
        vec_d      = vec_q;
        wait_d     = wait_q;
        errCnt_d   = errCnt_q;
        firstVec_d = firstVec_q;
        firstVld_d = firstVld_q;
`ifdef SEE_CHK_EXHAUSTIVE_EN
        genNext    = gen_q + N_IN'(1);
        lastVec    = (vec_q == '1);
`else
        idx_d      = idx_q;
        genNext    = {gen_q[N_IN-2:0], ^(gen_q & TAPS)};
        lastVec    = (idx_q == LAST_IDX);
`endif
        mismatch   = inj_en & (golden_i ^ faulty_i);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = APPLY;
                    errCnt_d   = '0;
                    firstVld_d = 1'b0;
                    gen_d      = START_VAL;
`ifndef SEE_CHK_EXHAUSTIVE_EN
                    idx_d      = '0;
`endif
                end
            end
            APPLY: begin
                vec_d = gen_q;
                if (SETTLE > 0) begin
                    state_d = WAIT;
                    wait_d  = WAIT_LOAD;
                end else begin
                    state_d = SAMPLE;
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (errCnt_q != '1) begin
                        errCnt_d = errCnt_q + CNT_W'(1);
                    end
                    if (!firstVld_q) begin
                        firstVec_d = vec_q;
                        firstVld_d = 1'b1;
                    end
                end
                gen_d = genNext;
`ifndef SEE_CHK_EXHAUSTIVE_EN
                idx_d = idx_q + IDX_W'(1);
`endif
                state_d = lastVec ? DONE : APPLY;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. The synchronous reset overrides everything, including a run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gen_q      <= START_VAL;
            vec_q      <= '0;
            wait_q     <= 4'd0;
            errCnt_q   <= '0;
            firstVec_q <= '0;
            firstVld_q <= 1'b0;
`ifndef SEE_CHK_EXHAUSTIVE_EN
            idx_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gen_q      <= gen_d;
            vec_q      <= vec_d;
            wait_q     <= wait_d;
            errCnt_q   <= errCnt_d;
            firstVec_q <= firstVec_d;
            firstVld_q <= firstVld_d;
`ifndef SEE_CHK_EXHAUSTIVE_EN
            idx_q      <= idx_d;
`endif
        end
    end

    assign vec_o         = vec_q;
    assign busy          = (state_q == APPLY) || (state_q == WAIT) || (state_q == SAMPLE);
    assign done          = (state_q == DONE);
    assign err_cnt       = errCnt_q;
    assign first_err_vec = firstVec_q;
    assign first_err_vld = firstVld_q;

endmodule

// File: tb/tb_see_cone_stim_checker.sv
// Self-checking bench for see_cone_stim_checker. It uses randomized cone
// responses and a vector-level reference model.
// Define SEE_CHK_EXHAUSTIVE_EN to exercise the exhaustive counter mode with SETTLE=0.
module tb_see_cone_stim_checker;

    localparam int N_IN  = 7;
    localparam int N_VEC = 128;
`ifdef SEE_CHK_EXHAUSTIVE_EN
    localparam int SETTLE   = 0;
    localparam int RUN_VECS = 1 << N_IN;
`else
    localparam int SETTLE   = 2;
    localparam int RUN_VECS = N_VEC;
`endif
    localparam int PER = SETTLE + 2;

    logic            clk;
    logic            rst;
    logic            start;
    logic            injEn;
    logic            goldenIn;
    logic            faultyIn;
    logic [6:0]      vecO;
    logic            busyO;
    logic            doneO;
    logic [15:0]     errCnt;
    logic [6:0]      firstVec;
    logic            firstVld;
    logic [6:0]      satVec;
    logic            satBusy;
    logic            satDone;
    logic [3:0]      satCnt;
    logic [6:0]      satFirstVec;
    logic            satFirstVld;

    int errors = 0;
    int checks = 0;

    logic [6:0] expVec [RUN_VECS];
    logic [6:0] obsVec [$];
    int         mCnt;
    logic [6:0] mFirst;
    bit         mVld;

    see_cone_stim_checker #(.N_IN(N_IN), .N_VEC(N_VEC), .SETTLE(SETTLE), .CNT_W(16), .SEED(7'h01)) dut (
        .clk(clk), .rst(rst), .start(start), .inj_en(injEn), .vec_o(vecO),
        .golden_i(goldenIn), .faulty_i(faultyIn), .busy(busyO), .done(doneO),
        .err_cnt(errCnt), .first_err_vec(firstVec), .first_err_vld(firstVld)
    );

    see_cone_stim_checker #(.N_IN(N_IN), .N_VEC(N_VEC), .SETTLE(SETTLE), .CNT_W(4), .SEED(7'h01)) dutSat (
        .clk(clk), .rst(rst), .start(start), .inj_en(injEn), .vec_o(satVec),
        .golden_i(goldenIn), .faulty_i(faultyIn), .busy(satBusy), .done(satDone),
        .err_cnt(satCnt), .first_err_vec(satFirstVec), .first_err_vld(satFirstVld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs a full vector sequence. mode: 0 = always agree, 1 = always disagree,
    // 2 = disagree only on vector 7'h40, 3 = random, 4 = always disagree with inj_en low.
    task automatic doRun(input int mode, input bit pokeStart);
        int busyBad;
        int vecBad;
        int k;
        busyBad = 0;
        vecBad  = 0;
        mCnt    = 0;
        mVld    = 1'b0;
        mFirst  = '0;
        obsVec.delete();
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= PER * RUN_VECS; i++) begin
            @(negedge clk);
            start = pokeStart && ((i % 37) == 5);
            if (busyO !== 1'b1 || doneO !== 1'b0) busyBad++;
            case (mode)
                0: begin injEn = 1'b1; goldenIn = 1'($urandom_range(0, 1)); faultyIn = goldenIn; end
                1: begin injEn = 1'b1; goldenIn = 1'($urandom_range(0, 1)); faultyIn = ~goldenIn; end
                2: begin injEn = 1'b1; goldenIn = 1'($urandom_range(0, 1)); faultyIn = goldenIn ^ (vecO == 7'h40); end
                3: begin injEn = 1'($urandom_range(0, 1)); goldenIn = 1'($urandom_range(0, 1)); faultyIn = 1'($urandom_range(0, 1)); end
                default: begin injEn = 1'b0; goldenIn = 1'($urandom_range(0, 1)); faultyIn = ~goldenIn; end
            endcase
            if ((i % PER) == 0) begin
                k = i / PER - 1;
                obsVec.push_back(vecO);
                if (vecO !== expVec[k]) vecBad++;
                if (injEn && (goldenIn != faultyIn)) begin
                    mCnt++;
                    if (!mVld) begin
                        mVld   = 1'b1;
                        mFirst = expVec[k];
                    end
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busyBad !== 0) begin
            errors++;
            $display("[TB] FAIL run_busy_window mode=%0d: bad cycles got %0d expected 0", mode, busyBad);
        end
        checks++;
        if (vecBad !== 0) begin
            errors++;
            $display("[TB] FAIL run_vector_sequence mode=%0d: wrong vectors got %0d expected 0", mode, vecBad);
        end
        checks++;
        if (busyO !== 1'b0 || doneO !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_end mode=%0d: busy/done got %b%b expected 01", mode, busyO, doneO);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        injEn = 1'b0;
        goldenIn = 1'b0;
        faultyIn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busyO !== 1'b0 || doneO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busyO, doneO);
        end
        checks++;
        if (errCnt !== 16'd0 || firstVld !== 1'b0 || firstVec !== 7'd0 || vecO !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: err=%0h vld=%b fvec=%0h vec=%0h expected all 0", errCnt, firstVld, firstVec, vecO);
        end
    endtask

    task automatic test_clean_run();
        bit seen [128];
        int distinct;
        int zeros;
        int lim;
        distinct = 0;
        zeros = 0;
        doRun(0, 1'b0);
        checks++;
        if (errCnt !== 16'd0 || firstVld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clean_err: err=%0d vld=%b expected 0 0", errCnt, firstVld);
        end
        checks++;
        if (obsVec.size() != RUN_VECS) begin
            errors++;
            $display("[TB] FAIL clean_vec_count: got %0d expected %0d", obsVec.size(), RUN_VECS);
        end else begin
`ifdef SEE_CHK_EXHAUSTIVE_EN
            lim = RUN_VECS;
`else
            lim = RUN_VECS - 1;
`endif
            for (int k = 0; k < lim; k++) begin
                if (obsVec[k] == 7'd0) zeros++;
                if (!seen[obsVec[k]]) begin
                    seen[obsVec[k]] = 1'b1;
                    distinct++;
                end
            end
            checks++;
            if (distinct != lim) begin
                errors++;
                $display("[TB] FAIL clean_distinct: got %0d expected %0d", distinct, lim);
            end
`ifndef SEE_CHK_EXHAUSTIVE_EN
            checks++;
            if (zeros != 0 || obsVec[RUN_VECS-1] !== obsVec[0]) begin
                errors++;
                $display("[TB] FAIL clean_lfsr_period: zeros=%0d last=%0h expected 0 and %0h", zeros, obsVec[RUN_VECS-1], obsVec[0]);
            end
`endif
        end
    endtask

    task automatic test_all_mismatch();
        doRun(1, 1'b0);
        checks++;
        if (errCnt !== 16'(RUN_VECS)) begin
            errors++;
            $display("[TB] FAIL all_mismatch_count: got %0d expected %0d", errCnt, RUN_VECS);
        end
        checks++;
        if (firstVld !== 1'b1 || firstVec !== expVec[0]) begin
            errors++;
            $display("[TB] FAIL all_mismatch_first: vld=%b vec=%0h expected 1 %0h", firstVld, firstVec, expVec[0]);
        end
        checks++;
        if (satCnt !== 4'hF) begin
            errors++;
            $display("[TB] FAIL saturation: got %0h expected f", satCnt);
        end
    endtask

    task automatic test_single_mismatch();
        doRun(2, 1'b0);
        checks++;
        if (errCnt !== 16'd1 || mCnt != 1) begin
            errors++;
            $display("[TB] FAIL single_mismatch_count: got %0d expected 1 (model %0d)", errCnt, mCnt);
        end
        checks++;
        if (firstVld !== 1'b1 || firstVec !== 7'h40) begin
            errors++;
            $display("[TB] FAIL single_mismatch_first: vld=%b vec=%0h expected 1 40", firstVld, firstVec);
        end
    endtask

    task automatic test_inj_disabled();
        doRun(4, 1'b0);
        checks++;
        if (errCnt !== 16'd0 || firstVld !== 1'b0 || satCnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL inj_disabled: err=%0d vld=%b sat=%0d expected 0 0 0", errCnt, firstVld, satCnt);
        end
    endtask

    task automatic test_random_back_to_back();
        int expSat;
        for (int r = 0; r < 2; r++) begin
            doRun(3, 1'b1);
            expSat = (mCnt > 15) ? 15 : mCnt;
            checks++;
            if (errCnt !== 16'(mCnt)) begin
                errors++;
                $display("[TB] FAIL random_count run=%0d: got %0d expected %0d", r, errCnt, mCnt);
            end
            checks++;
            if (firstVld !== mVld || (mVld && firstVec !== mFirst)) begin
                errors++;
                $display("[TB] FAIL random_first run=%0d: vld=%b vec=%0h expected %b %0h", r, firstVld, firstVec, mVld, mFirst);
            end
            checks++;
            if (satCnt !== 4'(expSat)) begin
                errors++;
                $display("[TB] FAIL random_sat run=%0d: got %0d expected %0d", r, satCnt, expSat);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        injEn = 1'b1;
        goldenIn = 1'b0;
        faultyIn = 1'b1;
        repeat (2 * PER + 2) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (busyO !== 1'b1 || errCnt !== 16'd2 || firstVld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_run_state: busy=%b err=%0d vld=%b expected 1 2 1", busyO, errCnt, firstVld);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busyO !== 1'b0 || doneO !== 1'b0 || errCnt !== 16'd0 || vecO !== 7'd0 || firstVld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_run_reset: busy=%b done=%b err=%0d vec=%0h vld=%b expected 0 0 0 0 0", busyO, doneO, errCnt, vecO, firstVld);
        end
        @(negedge clk);
        checks++;
        if (busyO !== 1'b0 || doneO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_run_stays_idle: busy=%b done=%b expected 0 0", busyO, doneO);
        end
    endtask

    initial begin
        logic [6:0] v;
`ifdef SEE_CHK_EXHAUSTIVE_EN
        for (int k = 0; k < RUN_VECS; k++) expVec[k] = 7'(k);
`else
        // Vector order follows x^7+x^6+1: each new low bit is the XOR of the x^7 and x^6 terms.
        v = 7'h01;
        for (int k = 0; k < RUN_VECS; k++) begin
            expVec[k] = v;
            v = {v[5:0], v[6] ^ v[5]};
        end
`endif
        rst = 1'b1;
        start = 1'b0;
        injEn = 1'b0;
        goldenIn = 1'b0;
        faultyIn = 1'b0;
        test_reset();
        test_clean_run();
        test_all_mismatch();
        test_single_mismatch();
        test_inj_disabled();
        test_random_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
